// File: rtl/npc_fetch_unit_pkg.sv
// Shared next-PC operation codes, comparator option codes and reset defaults
// for the IF-stage fetch unit.
package npc_fetch_unit_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CMP_W = 3;

    localparam logic [OP_W-1:0] NPC_SEQ = 3'b000;
    localparam logic [OP_W-1:0] NPC_BR  = 3'b001;
    localparam logic [OP_W-1:0] NPC_J   = 3'b010;
    localparam logic [OP_W-1:0] NPC_JR  = 3'b011;

    localparam logic [CMP_W-1:0] CMP_FALSE = 3'b000;
    localparam logic [CMP_W-1:0] CMP_EQUAL = 3'b001;
    localparam logic [CMP_W-1:0] CMP_TRUE  = 3'b111;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [PC_W-1:0] PC_MIN_DEFAULT   = 32'h0000_3000;
    localparam logic [PC_W-1:0] PC_MAX_DEFAULT   = 32'h0000_6FFC;

    // Target decision handed from the calculator to the PC owner.
    typedef struct packed {
        logic            want;
        logic            legal;
        logic [PC_W-1:0] target;
    } npc_tgt_t;

endpackage

// File: rtl/npc_target_calc.sv
// Pure combinational branch/jump/jr target computation plus fetch-window
// and alignment legality check.
module npc_target_calc
    import npc_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_MIN = PC_MIN_DEFAULT,
    parameter logic [PC_W-1:0] PC_MAX = PC_MAX_DEFAULT
) (
    input  logic [OP_W-1:0] npc_op_i,
    input  logic            cmp_res_i,
    input  logic [PC_W-1:0] id_pc_i,
    input  logic [15:0]     imm16_i,
    input  logic [25:0]     imm26_i,
    input  logic [PC_W-1:0] rs_val_i,
    output npc_tgt_t        tgt_o
);

    logic [PC_W-1:0] id_pc_plus4;
    logic [PC_W-1:0] br_off;

    assign id_pc_plus4 = id_pc_i + PC_W'(4);
    assign br_off      = {{14{imm16_i[15]}}, imm16_i, 2'b00};

    // Reserved op codes fall through to sequential with no redirect request.
    always_comb begin
        tgt_o        = '0;
        tgt_o.target = id_pc_plus4;
        case (npc_op_i)
            NPC_BR: begin
                tgt_o.want   = cmp_res_i;
                tgt_o.target = id_pc_plus4 + br_off;
            end
            NPC_J: begin
                tgt_o.want   = 1'b1;
                tgt_o.target = {id_pc_plus4[31:28], imm26_i, 2'b00};
            end
            NPC_JR: begin
                tgt_o.want   = 1'b1;
                tgt_o.target = rs_val_i;
            end
            default: begin
                tgt_o.want   = 1'b0;
                tgt_o.target = id_pc_plus4;
            end
        endcase
        tgt_o.legal = (tgt_o.target[1:0] == 2'b00) &&
                      (tgt_o.target >= PC_MIN) &&
                      (tgt_o.target <= PC_MAX);
    end

endmodule

// File: rtl/npc_fetch_unit.sv
// IF-stage PC owner: applies delayed-branch redirects from ID, freezes on
// hazard stall, latches a sticky fault on illegal targets and counts redirects.
module npc_fetch_unit
    import npc_fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] PC_MIN   = PC_MIN_DEFAULT,
    parameter logic [PC_W-1:0] PC_MAX   = PC_MAX_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [OP_W-1:0] npc_op,
    input  logic            cmp_res,
    input  logic [PC_W-1:0] id_pc,
    input  logic [15:0]     imm16,
    input  logic [25:0]     imm26,
    input  logic [PC_W-1:0] rs_val,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] link_addr,
    output logic            redirect,
    output logic            fault,
    output logic [PC_W-1:0] taken_cnt
);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FAULT = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [PC_W-1:0] cnt_q, cnt_d;
    npc_tgt_t        tgt;

    npc_target_calc #(
        .PC_MIN (PC_MIN),
        .PC_MAX (PC_MAX)
    ) u_target_calc (
        .npc_op_i  (npc_op),
        .cmp_res_i (cmp_res),
        .id_pc_i   (id_pc),
        .imm16_i   (imm16),
        .imm26_i   (imm26),
        .rs_val_i  (rs_val),
        .tgt_o     (tgt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Delay slot is never squashed: a redirect only replaces the fetch after it.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        redirect = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (tgt.want && tgt.legal) begin
                        pc_d     = tgt.target;
                        cnt_d    = cnt_q + PC_W'(1);
                        redirect = 1'b1;
                    end else if (tgt.want) begin
                        fault_d = 1'b1;
                        state_d = ST_FAULT;
                    end else begin
                        pc_d = pc_q + PC_W'(4);
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    assign pc        = pc_q;
    assign fault     = fault_q;
    assign taken_cnt = cnt_q;
    assign link_addr = id_pc + PC_W'(8);

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Scoreboard bench for npc_fetch_unit: a reference model predicts pc/fault/count
// per cycle; a monitor compares them one tick after each rising edge.
module tb_npc_fetch_unit;
    import npc_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  npc_op = 3'b000;
    logic        cmp_res = 1'b0;
    logic [31:0] id_pc = 32'h3000;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] imm26 = 26'h0;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] pc, link_addr, taken_cnt;
    logic        redirect, fault;

    typedef struct {
        logic [31:0] pc;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_pc = 32'h3000;
    logic [31:0] m_cnt = 32'h0;
    logic        m_fault = 1'b0;

    npc_fetch_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_op    (npc_op),
        .cmp_res   (cmp_res),
        .id_pc     (id_pc),
        .imm16     (imm16),
        .imm26     (imm26),
        .rs_val    (rs_val),
        .pc        (pc),
        .link_addr (link_addr),
        .redirect  (redirect),
        .fault     (fault),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (pc !== e.pc || fault !== e.fault || taken_cnt !== e.cnt) begin
                n_err++;
                $display("FAIL sb_state: got pc=%h fault=%b cnt=%0d, want pc=%h fault=%b cnt=%0d",
                         pc, fault, taken_cnt, e.pc, e.fault, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Called at a falling edge: drive one cycle, predict, return at next falling edge.
    task automatic drive(input logic st, input logic [2:0] op, input logic cmp,
                         input logic [31:0] ipc, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] rs);
        logic [31:0] tgt, p4;
        logic        want, legal, exp_redir;
        exp_t        e;
        stall = st; npc_op = op; cmp_res = cmp; id_pc = ipc;
        imm16 = i16; imm26 = i26; rs_val = rs;
        p4   = ipc + 32'd4;
        want = (op == 3'b001 && cmp) || op == 3'b010 || op == 3'b011;
        case (op)
            3'b001:  tgt = p4 + 32'($signed(i16)) * 32'd4;
            3'b010:  tgt = {p4[31:28], i26, 2'b00};
            3'b011:  tgt = rs;
            default: tgt = p4;
        endcase
        legal     = (tgt % 32'd4 == 32'd0) && tgt >= 32'h3000 && tgt <= 32'h6FFC;
        exp_redir = !m_fault && !st && want && legal;
        #1;
        n_vec++;
        if (redirect !== exp_redir) begin
            n_err++;
            $display("FAIL redirect: got %b want %b (op=%b stall=%b)", redirect, exp_redir, op, st);
        end
        if (!m_fault && !st) begin
            if (want && legal) begin
                m_pc  = tgt;
                m_cnt = m_cnt + 32'd1;
            end else if (want) begin
                m_fault = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc = m_pc; e.fault = m_fault; e.cnt = m_cnt;
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Mid-cycle asynchronous reset pulse, released on the next falling edge.
    task automatic do_reset();
        #2;
        reset   = 1'b1;
        m_pc    = 32'h3000;
        m_fault = 1'b0;
        m_cnt   = 32'h0;
        @(negedge clk);
        stall = 1'b0; npc_op = 3'b000;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 3'b000, 0, 32'h3000, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (pc !== 32'h3000 || fault !== 1'b0 || taken_cnt !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got pc=%h fault=%b cnt=%0d, want pc=00003000 fault=0 cnt=0",
                     pc, fault, taken_cnt);
        end
        m_pc = 32'h3000; m_fault = 1'b0; m_cnt = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) drive(0, 3'b000, 0, 32'h3000, 0, 0, 0);
        n_vec++;
        if (pc !== 32'h300C) begin
            n_err++;
            $display("FAIL seq_after_reset: got pc=%h want 0000300c", pc);
        end
    endtask

    task automatic test_branch();
        drive(0, NPC_BR, 1, 32'h3004, 16'hFFFF, 0, 0);
        n_vec++;
        if (pc !== 32'h3004 || taken_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL br_taken: got pc=%h cnt=%0d want pc=00003004 cnt=1", pc, taken_cnt);
        end
        drive(0, NPC_BR, 0, 32'h3004, 16'hFFFF, 0, 0);
        n_vec++;
        if (pc !== 32'h3008 || taken_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL br_not_taken: got pc=%h cnt=%0d want pc=00003008 cnt=1", pc, taken_cnt);
        end
    endtask

    task automatic test_stall();
        repeat (3) drive(1, NPC_J, 0, 32'h3008, 0, 26'h0000C10, 0);
        n_vec++;
        if (pc !== 32'h3008 || taken_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL stall_hold: got pc=%h cnt=%0d want pc=00003008 cnt=1", pc, taken_cnt);
        end
        drive(0, NPC_J, 0, 32'h3008, 0, 26'h0000C10, 0);
        n_vec++;
        if (pc !== 32'h3040 || taken_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL stall_release: got pc=%h cnt=%0d want pc=00003040 cnt=2", pc, taken_cnt);
        end
    endtask

    task automatic test_fault_sticky();
        drive(0, NPC_JR, 0, 32'h3040, 0, 0, 32'h3002);
        n_vec++;
        if (fault !== 1'b1 || pc !== 32'h3040 || taken_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL jr_misaligned: got pc=%h fault=%b cnt=%0d want pc=00003040 fault=1 cnt=2",
                     pc, fault, taken_cnt);
        end
        for (int i = 0; i < 5; i++)
            drive(0, (i % 2 == 0) ? NPC_SEQ : NPC_J, 0, 32'h3040, 0, 26'h0000C10, 0);
        n_vec++;
        if (fault !== 1'b1 || pc !== 32'h3040 || taken_cnt !== 32'd2) begin
            n_err++;
            $display("FAIL fault_hold: got pc=%h fault=%b cnt=%0d want pc=00003040 fault=1 cnt=2",
                     pc, fault, taken_cnt);
        end
        do_reset();
        n_vec++;
        if (fault !== 1'b0 || pc !== 32'h3000 || taken_cnt !== 32'd0) begin
            n_err++;
            $display("FAIL fault_reset: got pc=%h fault=%b cnt=%0d want pc=00003000 fault=0 cnt=0",
                     pc, fault, taken_cnt);
        end
    endtask

    task automatic test_range();
        drive(0, NPC_JR, 0, 32'h3000, 0, 0, 32'h7000);
        n_vec++;
        if (fault !== 1'b1 || pc !== 32'h3000) begin
            n_err++;
            $display("FAIL jr_above_max: got pc=%h fault=%b want pc=00003000 fault=1", pc, fault);
        end
        do_reset();
        drive(0, NPC_JR, 0, 32'h3000, 0, 0, 32'h6FFC);
        n_vec++;
        if (fault !== 1'b0 || pc !== 32'h6FFC || taken_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL jr_at_max: got pc=%h fault=%b cnt=%0d want pc=00006ffc fault=0 cnt=1",
                     pc, fault, taken_cnt);
        end
        drive(0, NPC_SEQ, 0, 32'h6FF8, 0, 0, 0);
        n_vec++;
        if (fault !== 1'b0 || pc !== 32'h7000) begin
            n_err++;
            $display("FAIL seq_past_max: got pc=%h fault=%b want pc=00007000 fault=0", pc, fault);
        end
        do_reset();
        drive(0, NPC_JR, 0, 32'h3000, 0, 0, 32'h2FFC);
        n_vec++;
        if (fault !== 1'b1) begin
            n_err++;
            $display("FAIL jr_below_min: got fault=%b want 1", fault);
        end
        do_reset();
        drive(0, NPC_JR, 0, 32'h3000, 0, 0, 32'h3000);
        n_vec++;
        if (fault !== 1'b0 || pc !== 32'h3000 || taken_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL jr_at_min: got pc=%h fault=%b cnt=%0d want pc=00003000 fault=0 cnt=1",
                     pc, fault, taken_cnt);
        end
    endtask

    task automatic test_link_and_reserved();
        drive(0, 3'b110, 1, 32'h3010, 16'h0010, 26'h0000C10, 32'h3002);
        n_vec++;
        if (link_addr !== 32'h3018) begin
            n_err++;
            $display("FAIL link_addr: got %h want 00003018", link_addr);
        end
        n_vec++;
        if (pc !== 32'h3004 || fault !== 1'b0 || taken_cnt !== 32'd1) begin
            n_err++;
            $display("FAIL op_reserved: got pc=%h fault=%b cnt=%0d want pc=00003004 fault=0 cnt=1",
                     pc, fault, taken_cnt);
        end
        drive(0, 3'b111, 1, 32'h3010, 16'h0010, 0, 32'h7000);
        n_vec++;
        if (pc !== 32'h3008 || fault !== 1'b0) begin
            n_err++;
            $display("FAIL op_reserved_111: got pc=%h fault=%b want pc=00003008 fault=0", pc, fault);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rs_tab [4];
        rs_tab[0] = 32'h3100; rs_tab[1] = 32'h4000; rs_tab[2] = 32'h6FFC; rs_tab[3] = 32'h5002;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 30; i++) begin
                logic [31:0] ipc;
                ipc = 32'h3000 + 32'($urandom_range(0, 32'hFF0)) * 32'd4;
                drive(($urandom_range(0, 4) == 0), 3'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)), ipc,
                      16'($signed(8'($urandom_range(0, 255)))),
                      26'($urandom_range(32'hC00, 32'h1BFF)),
                      rs_tab[$urandom_range(0, 3)]);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_branch();
        test_stall();
        test_fault_sticky();
        test_range();
        test_link_and_reserved();
        test_back_to_back();
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
